hazard3_bus_arb: RTL and testbench

Two-master, one-slave arbiter that merges the core's instruction-fetch port and load/store port onto a single memory port, so the noMAC core variant runs from one iCE40 SPRAM/BRAM controller. Sits between the core wrapper and the memory controller. Pipelined address/data-phase handshake identical to the core's own port protocol; adds zero cycles of latency on an uncontended access.

---
 rtl/hazard3_arb_pkg.sv | 15 +
 rtl/hazard3_arb_fair_ctr.sv | 32 +++
 rtl/hazard3_bus_arb.sv | 144 ++++++++++++++
 tb/tb_hazard3_bus_arb.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard3_arb_pkg.sv
// Shared types and constants for the Hazard3 two-master bus arbiter.
package hazard3_arb_pkg;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_I    = 2'd1,
    OWNER_D    = 2'd2
  } owner_t;

  localparam logic MASTER_I = 1'b0;
  localparam logic MASTER_D = 1'b1;

  localparam int unsigned STREAK_W = 4;

endpackage

// File: rtl/hazard3_arb_fair_ctr.sv
// Counts D grants won against a waiting I port; raises prio_i once the streak limit is hit.
module hazard3_arb_fair_ctr
  import hazard3_arb_pkg::*;
#(
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_accept,
  input  logic d_accept,
  input  logic i_req,
  output logic prio_i
);

  localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(MAX_D_STREAK);

  logic [STREAK_W-1:0] streak;

  // Saturates at the limit so priority stays with I until I is actually accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak <= '0;
    end else if (i_accept) begin
      streak <= '0;
    end else if (d_accept && i_req && (streak != STREAK_LIMIT)) begin
      streak <= streak + STREAK_W'(1);
    end
  end

  assign prio_i = (streak == STREAK_LIMIT);

endmodule

// File: rtl/hazard3_bus_arb.sv
// Merges Hazard3 I-fetch and load/store ports onto one memory port, D > I priority.
// Define HAZARD3_ARB_FAIR_EN to bound D streaks so a waiting I port is eventually served.
module hazard3_bus_arb
  import hazard3_arb_pkg::*;
#(
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        i_aph_req,
  input  logic        i_aph_panic,
  input  logic [31:0] i_haddr,
  input  logic [2:0]  i_hsize,
  input  logic        i_priv,
  output logic        i_aph_ready,
  output logic        i_dph_ready,
  output logic        i_dph_err,
  output logic [31:0] i_rdata,

  input  logic        d_aph_req,
  input  logic        d_aph_excl,
  input  logic [31:0] d_haddr,
  input  logic [2:0]  d_hsize,
  input  logic        d_priv,
  input  logic        d_hwrite,
  input  logic [31:0] d_wdata,
  output logic        d_aph_ready,
  output logic        d_dph_ready,
  output logic        d_dph_err,
  output logic        d_dph_exokay,
  output logic [31:0] d_rdata,

  output logic        m_aph_req,
  output logic        m_aph_excl,
  output logic [31:0] m_haddr,
  output logic [2:0]  m_hsize,
  output logic        m_priv,
  output logic        m_hwrite,
  output logic [31:0] m_wdata,
  input  logic        m_aph_ready,
  input  logic        m_dph_ready,
  input  logic        m_dph_err,
  input  logic        m_dph_exokay,
  input  logic [31:0] m_rdata
);

  if (MAX_D_STREAK < 1 || MAX_D_STREAK > 15) begin : g_max_d_streak_range
    $error("MAX_D_STREAK must be in 1..15");
  end

  logic [1:0] req;
  logic [1:0] gnt;
  logic [1:0] lock;
  logic       i_held;
  logic       d_held;
  logic       prio_i;
  logic       aph_accept;
  owner_t     dph_owner;

  assign req[MASTER_I] = i_aph_req & rst_n;
  assign req[MASTER_D] = d_aph_req & rst_n;

  // A panicking I port may retarget its stalled address, so its lock is void
  assign i_held = lock[MASTER_I] & req[MASTER_I] & ~i_aph_panic;
  assign d_held = lock[MASTER_D] & req[MASTER_D];

  always_comb begin
    gnt = '0;
    if (d_held) begin
      gnt[MASTER_D] = 1'b1;
    end else if (i_held) begin
      gnt[MASTER_I] = 1'b1;
    end else if (req[MASTER_D] && !(prio_i && req[MASTER_I])) begin
      gnt[MASTER_D] = 1'b1;
    end else if (req[MASTER_I]) begin
      gnt[MASTER_I] = 1'b1;
    end
  end

`ifdef HAZARD3_ARB_FAIR_EN
  hazard3_arb_fair_ctr #(
    .MAX_D_STREAK (MAX_D_STREAK)
  ) u_fair_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_accept (i_aph_ready),
    .d_accept (d_aph_ready),
    .i_req    (req[MASTER_I]),
    .prio_i   (prio_i)
  );
`else
  assign prio_i = 1'b0;
`endif

  always_comb begin
    m_aph_excl = 1'b0;
    m_haddr    = '0;
    m_hsize    = '0;
    m_priv     = 1'b0;
    m_hwrite   = 1'b0;
    if (gnt[MASTER_D]) begin
      m_aph_excl = d_aph_excl;
      m_haddr    = d_haddr;
      m_hsize    = d_hsize;
      m_priv     = d_priv;
      m_hwrite   = d_hwrite;
    end else if (gnt[MASTER_I]) begin
      m_haddr    = i_haddr;
      m_hsize    = i_hsize;
      m_priv     = i_priv;
    end
  end

  assign m_aph_req   = |gnt;
  assign i_aph_ready = gnt[MASTER_I] & m_aph_ready;
  assign d_aph_ready = gnt[MASTER_D] & m_aph_ready;
  assign aph_accept  = m_aph_req & m_aph_ready;

  // Lock and data-phase owner; acceptance takes precedence over completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock      <= '0;
      dph_owner <= OWNER_NONE;
    end else begin
      lock <= m_aph_ready ? 2'b00 : gnt;
      if (aph_accept) begin
        dph_owner <= gnt[MASTER_D] ? OWNER_D : OWNER_I;
      end else if (m_dph_ready) begin
        dph_owner <= OWNER_NONE;
      end
    end
  end

  assign i_dph_ready  = (dph_owner == OWNER_I) && m_dph_ready;
  assign i_dph_err    = (dph_owner == OWNER_I) && m_dph_err;
  assign d_dph_ready  = (dph_owner == OWNER_D) && m_dph_ready;
  assign d_dph_err    = (dph_owner == OWNER_D) && m_dph_err;
  assign d_dph_exokay = (dph_owner == OWNER_D) && m_dph_exokay;
  assign m_wdata      = (dph_owner == OWNER_D) ? d_wdata : 32'h0;
  assign i_rdata      = rst_n ? m_rdata : 32'h0;
  assign d_rdata      = rst_n ? m_rdata : 32'h0;

endmodule

// File: tb/tb_hazard3_bus_arb.sv
// Self-checking bench for hazard3_bus_arb: vector table, corner-case sequences, random vs model.
module tb_hazard3_bus_arb;

  localparam int MAX_D_STREAK = 4;
`ifdef HAZARD3_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic i_aph_req, i_aph_panic, i_priv;
  logic [31:0] i_haddr;
  logic [2:0] i_hsize;
  logic i_aph_ready, i_dph_ready, i_dph_err;
  logic [31:0] i_rdata;
  logic d_aph_req, d_aph_excl, d_priv, d_hwrite;
  logic [31:0] d_haddr, d_wdata;
  logic [2:0] d_hsize;
  logic d_aph_ready, d_dph_ready, d_dph_err, d_dph_exokay;
  logic [31:0] d_rdata;
  logic m_aph_req, m_aph_excl, m_priv, m_hwrite;
  logic [31:0] m_haddr, m_wdata;
  logic [2:0] m_hsize;
  logic m_aph_ready, m_dph_ready, m_dph_err, m_dph_exokay;
  logic [31:0] m_rdata;

  always #5 clk = ~clk;

  hazard3_bus_arb #(.MAX_D_STREAK(MAX_D_STREAK)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_aph_req(i_aph_req), .i_aph_panic(i_aph_panic), .i_haddr(i_haddr), .i_hsize(i_hsize),
    .i_priv(i_priv), .i_aph_ready(i_aph_ready), .i_dph_ready(i_dph_ready),
    .i_dph_err(i_dph_err), .i_rdata(i_rdata),
    .d_aph_req(d_aph_req), .d_aph_excl(d_aph_excl), .d_haddr(d_haddr), .d_hsize(d_hsize),
    .d_priv(d_priv), .d_hwrite(d_hwrite), .d_wdata(d_wdata), .d_aph_ready(d_aph_ready),
    .d_dph_ready(d_dph_ready), .d_dph_err(d_dph_err), .d_dph_exokay(d_dph_exokay),
    .d_rdata(d_rdata),
    .m_aph_req(m_aph_req), .m_aph_excl(m_aph_excl), .m_haddr(m_haddr), .m_hsize(m_hsize),
    .m_priv(m_priv), .m_hwrite(m_hwrite), .m_wdata(m_wdata), .m_aph_ready(m_aph_ready),
    .m_dph_ready(m_dph_ready), .m_dph_err(m_dph_err), .m_dph_exokay(m_dph_exokay),
    .m_rdata(m_rdata)
  );

  wire [10:0] hs_act = {i_aph_ready, i_dph_ready, i_dph_err, d_aph_ready, d_dph_ready,
                        d_dph_err, d_dph_exokay, m_aph_req, m_aph_excl, m_hwrite, m_priv};
  wire out_nonzero = |{hs_act, i_rdata, d_rdata, m_haddr, m_hsize, m_wdata};

  int n_pass = 0;
  int n_total = 0;

  // Reference state: who holds the address phase (0 none, 1 I, 2 D), who owns the data phase
  int mdl_lock, mdl_owner, mdl_streak;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic int mdl_grant();
    if (!rst_n) return 0;
    if (mdl_lock == 2 && d_aph_req) return 2;
    if (mdl_lock == 1 && i_aph_req && !i_aph_panic) return 1;
    if (i_aph_req && d_aph_req) return (FAIR && mdl_streak >= MAX_D_STREAK) ? 1 : 2;
    if (d_aph_req) return 2;
    if (i_aph_req) return 1;
    return 0;
  endfunction

  task automatic check_model(input string tag);
    int g;
    logic [10:0] hs_exp;
    logic [31:0] addr_exp;
    logic [2:0] size_exp;
    g = mdl_grant();
    addr_exp = (g == 1) ? i_haddr : (g == 2) ? d_haddr : 32'h0;
    size_exp = (g == 1) ? i_hsize : (g == 2) ? d_hsize : 3'h0;
    hs_exp = {g == 1 && m_aph_ready, mdl_owner == 1 && m_dph_ready, mdl_owner == 1 && m_dph_err,
              g == 2 && m_aph_ready, mdl_owner == 2 && m_dph_ready, mdl_owner == 2 && m_dph_err,
              mdl_owner == 2 && m_dph_exokay, g != 0, g == 2 && d_aph_excl, g == 2 && d_hwrite,
              (g == 1) ? i_priv : (g == 2) ? d_priv : 1'b0};
    check({tag, ".handshake"}, 32'(hs_act), 32'(hs_exp));
    check({tag, ".m_haddr"}, m_haddr, addr_exp);
    check({tag, ".m_hsize"}, 32'(m_hsize), 32'(size_exp));
    check({tag, ".m_wdata"}, m_wdata, (mdl_owner == 2) ? d_wdata : 32'h0);
    check({tag, ".i_rdata"}, i_rdata, rst_n ? m_rdata : 32'h0);
    check({tag, ".d_rdata"}, d_rdata, rst_n ? m_rdata : 32'h0);
  endtask

  task automatic tick();
    int g;
    g = mdl_grant();
    if (!rst_n) begin
      mdl_lock = 0; mdl_owner = 0; mdl_streak = 0;
    end else begin
      if (g != 0 && m_aph_ready) begin
        if (g == 1) mdl_streak = 0;
        else if (i_aph_req && mdl_streak < MAX_D_STREAK) mdl_streak++;
        mdl_owner = g;
      end else if (m_dph_ready) begin
        mdl_owner = 0;
      end
      mdl_lock = (g != 0 && !m_aph_ready) ? g : 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_aph_req = 0; i_aph_panic = 0; i_haddr = 0; i_hsize = 0; i_priv = 0;
    d_aph_req = 0; d_aph_excl = 0; d_haddr = 0; d_hsize = 0; d_priv = 0; d_hwrite = 0;
    d_wdata = 0; m_aph_ready = 0; m_dph_ready = 0; m_dph_err = 0; m_dph_exokay = 0; m_rdata = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    mdl_lock = 0; mdl_owner = 0; mdl_streak = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  typedef struct {
    logic i_req; logic [31:0] i_addr; logic d_req; logic d_write; logic [31:0] d_addr;
    logic m_ardy; logic [31:0] e_haddr; logic e_m_req; logic e_i_ardy; logic e_d_ardy;
    logic e_hwrite;
  } vec_t;

  vec_t vecs[7];
  int n_d;
  bit i_won;

  initial begin
    vecs[0] = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h8000, 1'b1, 32'h100,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 32'h100, 1'b1, 1'b1, 32'h8000, 1'b1, 32'h8000, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 32'h200, 1'b1, 1'b1, 32'h8000, 1'b1, 32'h8000, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 32'h200, 1'b1, 1'b1, 32'h8000, 1'b0, 32'h8000, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 32'h200, 1'b0, 1'b1, 32'h8000, 1'b1, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 32'h100, 1'b0, 1'b1, 32'h8000, 1'b1, 32'h100,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 32'h200, 1'b1, 1'b0, 32'h4000, 1'b1, 32'h4000, 1'b1, 1'b0, 1'b1, 1'b0};

    // Reset: outputs must be zero even with every input active
    rst_n = 0;
    mdl_lock = 0; mdl_owner = 0; mdl_streak = 0;
    idle_inputs();
    i_aph_req = 1; d_aph_req = 1; d_hwrite = 1; d_wdata = 32'hFFFF_FFFF; i_haddr = 32'h100;
    d_haddr = 32'h8000; m_aph_ready = 1; m_dph_ready = 1; m_dph_err = 1; m_dph_exokay = 1;
    m_rdata = 32'hA5A5_A5A5;
    #1;
    check("reset.outputs_zero", 32'(out_nonzero), 32'h0);
    check_model("reset");
    do_reset();

    for (int k = 0; k < 7; k++) begin
      idle_inputs();
      i_aph_req = vecs[k].i_req; i_haddr = vecs[k].i_addr; d_aph_req = vecs[k].d_req;
      d_hwrite = vecs[k].d_write; d_haddr = vecs[k].d_addr; m_aph_ready = vecs[k].m_ardy;
      #1;
      check($sformatf("vec%0d.m_haddr", k), m_haddr, vecs[k].e_haddr);
      check($sformatf("vec%0d.m_aph_req", k), 32'(m_aph_req), 32'(vecs[k].e_m_req));
      check($sformatf("vec%0d.i_aph_ready", k), 32'(i_aph_ready), 32'(vecs[k].e_i_ardy));
      check($sformatf("vec%0d.d_aph_ready", k), 32'(d_aph_ready), 32'(vecs[k].e_d_ardy));
      check($sformatf("vec%0d.m_hwrite", k), 32'(m_hwrite), 32'(vecs[k].e_hwrite));
      tick();
      idle_inputs(); m_dph_ready = 1;
      #1;
      tick();
    end

    // I-only read, slave completes one cycle later
    do_reset();
    i_aph_req = 1; i_haddr = 32'h100; i_hsize = 3'd2; m_aph_ready = 1;
    #1;
    check("iread.i_aph_ready", 32'(i_aph_ready), 32'h1);
    check_model("iread.c0");
    tick();
    i_aph_req = 0; m_aph_ready = 0; m_dph_ready = 1; m_rdata = 32'h1234_5678;
    #1;
    check("iread.i_dph_ready", 32'(i_dph_ready), 32'h1);
    check("iread.i_rdata", i_rdata, 32'h1234_5678);
    check("iread.d_dph_ready", 32'(d_dph_ready), 32'h0);
    check_model("iread.c1");
    tick();

    // Simultaneous requests: D write first, I pipelined behind it
    do_reset();
    i_aph_req = 1; i_haddr = 32'h200; d_aph_req = 1; d_haddr = 32'h8000; d_hwrite = 1;
    d_wdata = 32'hDEAD_BEEF; m_aph_ready = 1;
    #1;
    check("both.c0.m_haddr", m_haddr, 32'h8000);
    check("both.c0.d_aph_ready", 32'(d_aph_ready), 32'h1);
    check("both.c0.i_aph_ready", 32'(i_aph_ready), 32'h0);
    tick();
    d_aph_req = 0; m_dph_ready = 1;
    #1;
    check("both.c1.m_wdata", m_wdata, 32'hDEAD_BEEF);
    check("both.c1.d_dph_ready", 32'(d_dph_ready), 32'h1);
    check("both.c1.i_aph_ready", 32'(i_aph_ready), 32'h1);
    check("both.c1.m_haddr", m_haddr, 32'h200);
    check_model("both.c1");
    tick();
    i_aph_req = 0; m_aph_ready = 0;
    #1;
    check("both.c2.i_dph_ready", 32'(i_dph_ready), 32'h1);
    check("both.c2.m_wdata", m_wdata, 32'h0);
    tick();

    // I stalled three cycles; D arriving meanwhile must not steal the grant
    do_reset();
    i_aph_req = 1; i_haddr = 32'h100; d_haddr = 32'h8000;
    for (int c = 0; c < 3; c++) begin
      d_aph_req = (c >= 1);
      #1;
      check($sformatf("stall.c%0d.m_haddr", c), m_haddr, 32'h100);
      check($sformatf("stall.c%0d.d_aph_ready", c), 32'(d_aph_ready), 32'h0);
      check_model("stall");
      tick();
    end
    m_aph_ready = 1;
    #1;
    check("stall.c3.i_aph_ready", 32'(i_aph_ready), 32'h1);
    tick();
    i_aph_req = 0; m_dph_ready = 1;
    #1;
    check("stall.c4.m_haddr", m_haddr, 32'h8000);
    check("stall.c4.d_aph_ready", 32'(d_aph_ready), 32'h1);
    check("stall.c4.i_dph_ready", 32'(i_dph_ready), 32'h1);
    tick();

    // Panic releases an I lock, alone and with D competing; then a locked master drops out
    do_reset();
    i_aph_req = 1; i_haddr = 32'h200;
    #1; tick();
    i_aph_panic = 1; i_haddr = 32'h300; m_aph_ready = 1;
    #1;
    check("panic.alone.m_haddr", m_haddr, 32'h300);
    check("panic.alone.i_aph_ready", 32'(i_aph_ready), 32'h1);
    tick();
    i_aph_panic = 0; i_haddr = 32'h200; m_aph_ready = 0; m_dph_ready = 1;
    #1; tick();
    i_aph_panic = 1; i_haddr = 32'h300; d_aph_req = 1; d_haddr = 32'h8000; m_aph_ready = 1;
    #1;
    check("panic.d.m_haddr", m_haddr, 32'h8000);
    check("panic.d.d_aph_ready", 32'(d_aph_ready), 32'h1);
    check("panic.d.i_aph_ready", 32'(i_aph_ready), 32'h0);
    tick();
    i_aph_panic = 0; d_aph_req = 0; i_haddr = 32'h200; m_aph_ready = 0;
    #1; tick();
    i_aph_req = 0; d_aph_req = 1;
    #1;
    check("drop.m_haddr", m_haddr, 32'h8000);
    check_model("drop");
    tick();

    // D streaming with I waiting: fair build serves I after the streak limit, otherwise I starves
    do_reset();
    i_aph_req = 1; i_haddr = 32'h400; d_aph_req = 1; d_haddr = 32'h8000; d_hwrite = 1;
    m_aph_ready = 1; m_dph_ready = 1;
    n_d = 0; i_won = 0;
    for (int c = 0; c < 20 && !i_won; c++) begin
      d_wdata = $urandom;
      #1;
      check_model("streak");
      if (i_aph_ready) i_won = 1;
      else if (d_aph_ready) n_d++;
      tick();
    end
`ifdef HAZARD3_ARB_FAIR_EN
    check("fair.i_accepted", 32'(i_won), 32'h1);
    check("fair.d_accepts_before_i", n_d, MAX_D_STREAK);
`else
    check("starve.i_accepted", 32'(i_won), 32'h0);
    check("starve.d_accepts", n_d, 20);
`endif

    // Reset asserted during a D data phase
    do_reset();
    d_aph_req = 1; d_hwrite = 1; d_haddr = 32'h8000; d_wdata = 32'hDEAD_BEEF; m_aph_ready = 1;
    #1;
    check("rstmid.d_aph_ready", 32'(d_aph_ready), 32'h1);
    tick();
    d_aph_req = 0;
    #1;
    check("rstmid.m_wdata", m_wdata, 32'hDEAD_BEEF);
    rst_n = 0;
    mdl_lock = 0; mdl_owner = 0; mdl_streak = 0;
    m_dph_ready = 1; m_rdata = 32'hCAFE_F00D; d_aph_req = 1; i_aph_req = 1;
    #1;
    check("rstmid.outputs_zero", 32'(out_nonzero), 32'h0);
    check("rstmid.d_dph_ready", 32'(d_dph_ready), 32'h0);
    tick();
    check("rstmid.held.outputs_zero", 32'(out_nonzero), 32'h0);
    rst_n = 1; d_aph_req = 0; i_aph_req = 0;
    #1;
    check("rstmid.after.d_dph_ready", 32'(d_dph_ready), 32'h0);
    check("rstmid.after.m_wdata", m_wdata, 32'h0);
    check_model("rstmid.after");
    tick();

    // Random traffic against the reference model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      i_aph_req = ($urandom_range(0, 3) != 0); i_aph_panic = ($urandom_range(0, 7) == 0);
      i_haddr = $urandom; i_hsize = 3'($urandom_range(0, 2)); i_priv = 1'($urandom);
      d_aph_req = ($urandom_range(0, 2) != 0); d_aph_excl = 1'($urandom);
      d_haddr = $urandom; d_hsize = 3'($urandom_range(0, 2)); d_priv = 1'($urandom);
      d_hwrite = 1'($urandom); d_wdata = $urandom;
      m_aph_ready = ($urandom_range(0, 3) != 0); m_dph_ready = 1'($urandom);
      m_dph_err = ($urandom_range(0, 7) == 0); m_dph_exokay = 1'($urandom); m_rdata = $urandom;
      #1;
      check_model($sformatf("rand%0d", c));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
